// File: rtl/system_lcd_data_in.sv
// LCD data-bus readback port: synchronized input, edge capture, mask, level irq.
// Optional macro SYSTEM_LCD_DATA_IN_BITCLR_EN selects write-1-to-clear on EDGE_CAPTURE.
module system_lcd_data_in (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [7:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [DW-1:0] r_s1;
    logic [DW-1:0] r_s2;
    logic [DW-1:0] r_s3;
    logic [DW-1:0] r_irq_mask;
    logic [DW-1:0] r_edge_cap;
    logic [RW-1:0] r_readdata;

    logic          w_wr;
    logic [DW-1:0] w_edge;
    logic [DW-1:0] w_clr;
    logic [DW-1:0] w_rd_mux;
    logic [RW-DW-1:0] w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_edge         = r_s2 ^ r_s3;
    assign w_unused_wdata = writedata[RW-1:DW];

    // Clear vector for EDGE_CAPTURE; zero unless this cycle writes address 3.
    always_comb begin
        w_clr = '0;
        if (w_wr && (address == ADDR_EDGE)) begin
`ifdef SYSTEM_LCD_DATA_IN_BITCLR_EN
            w_clr = writedata[DW-1:0];
`else
            w_clr = '1;
`endif
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux = r_s2;
            ADDR_MASK: w_rd_mux = r_irq_mask;
            ADDR_EDGE: w_rd_mux = r_edge_cap;
            default:   w_rd_mux = '0;
        endcase
    end

    // Two-flop synchronizer plus history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Register file; set has priority over clear in EDGE_CAPTURE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_readdata <= '0;
        end else begin
            if (w_wr && (address == ADDR_MASK)) begin
                r_irq_mask <= writedata[DW-1:0];
            end
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            r_readdata <= {(RW-DW)'(0), w_rd_mux};
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_system_lcd_data_in.sv
// Self-checking bench for system_lcd_data_in against a sample-history reference model.
module tb_system_lcd_data_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in_port = 8'd0;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    system_lcd_data_in dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: samp[k] is in_port seen at the k-th edge since reset release.
    // DATA visible before edge n is the sample from edge n-2; an edge is flagged when
    // samples n-2 and n-3 differ.
    logic [7:0]  samp [0:8191];
    int          m_cyc = 0;
    logic [7:0]  m_mask = 8'd0;
    logic [7:0]  m_cap = 8'd0;
    logic [31:0] m_rd = 32'd0;
    logic        m_irq;

    assign m_irq = |(m_cap & m_mask);

    function automatic logic [7:0] s_at(input int k);
        if (k < 1) return 8'd0;
        return samp[k];
    endfunction

    function automatic logic [7:0] clr_now();
        if (!(chipselect && !write_n && address == 2'd3)) return 8'd0;
`ifdef SYSTEM_LCD_DATA_IN_BITCLR_EN
        return writedata[7:0];
`else
        return 8'hFF;
`endif
    endfunction

    function automatic logic [7:0] view(input logic [1:0] a);
        case (a)
            2'd0:    return s_at(m_cyc - 1);
            2'd2:    return m_mask;
            2'd3:    return m_cap;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc  <= 0;
            m_mask <= 8'd0;
            m_cap  <= 8'd0;
            m_rd   <= 32'd0;
        end else begin
            samp[m_cyc + 1] <= in_port;
            m_cyc <= m_cyc + 1;
            m_cap <= (m_cap & ~clr_now()) | (s_at(m_cyc - 1) ^ s_at(m_cyc - 2));
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[7:0];
            m_rd <= {24'd0, view(address)};
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        v = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0; in_port = 8'hFF;
        tick(3);
        checks++; if (readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'd0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset_n = 1'b1;
        tick(4);
        rd(2'd0, v);
        checks++; if (v !== 32'h0000_00FF || v !== m_rd) begin failures++; $display("FAIL reset_data got=%h exp=%h", v, 32'h0000_00FF); end
        rd(2'd3, v);
        checks++; if (v !== 32'h0000_00FF || v !== m_rd) begin failures++; $display("FAIL reset_edge_cap got=%h exp=%h", v, 32'h0000_00FF); end
    endtask

    task automatic test_data_read();
        logic [31:0] v;
        in_port = 8'hA5;
        tick(4);
        rd(2'd0, v);
        checks++; if (v !== 32'h0000_00A5 || v !== m_rd) begin failures++; $display("FAIL data_read got=%h exp=%h", v, 32'h0000_00A5); end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        wr(2'd2, 32'h0000_0001);
        in_port = 8'h00;
        tick(4);
        wr(2'd3, 32'h0000_00FF);
        rd(2'd3, v);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL irq_cleared got=%h exp=0", v); end
        in_port = 8'h01;
        tick(1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_edge1 got=%b exp=0", irq); end
        tick(1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_edge2 got=%b exp=0", irq); end
        tick(1);
        checks++; if (irq !== 1'b1 || irq !== m_irq) begin failures++; $display("FAIL irq_edge3 got=%b exp=1", irq); end
        in_port = 8'h03;
        tick(4);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_masked_bit got=%b exp=1", irq); end
        rd(2'd3, v);
        checks++; if (v !== 32'h0000_0003 || v !== m_rd) begin failures++; $display("FAIL irq_cap_bit1 got=%h exp=%h", v, 32'h3); end
    endtask

    task automatic test_clear();
        logic [31:0] v;
        logic [31:0] exp;
`ifdef SYSTEM_LCD_DATA_IN_BITCLR_EN
        exp = 32'h0000_0002;
`else
        exp = 32'h0000_0000;
`endif
        wr(2'd3, 32'h0000_0001);
        rd(2'd3, v);
        checks++; if (v !== exp || v !== m_rd) begin failures++; $display("FAIL clear got=%h exp=%h", v, exp); end
    endtask

    task automatic test_set_beats_clear();
        logic [31:0] v;
        in_port = 8'h02;
        tick(4);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL sbc_pre_irq got=%b exp=1", irq); end
        in_port = 8'h03;
        tick(2);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL sbc_mid_irq got=%b exp=1", irq); end
        wr(2'd3, 32'h0000_0001);
        checks++; if (irq !== 1'b1 || irq !== m_irq) begin failures++; $display("FAIL sbc_irq got=%b exp=1", irq); end
        rd(2'd3, v);
        checks++; if (v[0] !== 1'b1 || v !== m_rd) begin failures++; $display("FAIL sbc_cap0 got=%h model=%h", v, m_rd); end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] v, pre_mask, pre_cap;
        logic [7:0]  d;
        d = 8'($urandom);
        in_port = d;
        tick(4);
        rd(2'd2, pre_mask);
        rd(2'd3, pre_cap);
        wr(2'd0, 32'h0000_00FF);
        wr(2'd1, 32'h0000_00FF);
        rd(2'd0, v);
        checks++; if (v !== {24'd0, d}) begin failures++; $display("FAIL ign_data got=%h exp=%h", v, {24'd0, d}); end
        rd(2'd1, v);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL ign_reserved got=%h exp=0", v); end
        rd(2'd2, v);
        checks++; if (v !== pre_mask || v !== m_rd) begin failures++; $display("FAIL ign_mask got=%h exp=%h", v, pre_mask); end
        rd(2'd3, v);
        checks++; if (v !== pre_cap || v !== m_rd) begin failures++; $display("FAIL ign_cap got=%h exp=%h", v, pre_cap); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        wr(2'd2, 32'h0000_00FF);
        in_port = ~in_port;
        tick(4);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (readdata !== 32'd0 || irq !== 1'b0) begin failures++; $display("FAIL midreset_async rd=%h irq=%b exp=0", readdata, irq); end
        in_port = 8'h5C;
        @(negedge clk);
        reset_n = 1'b1;
        tick(3);
        rd(2'd3, v);
        checks++; if (v !== 32'h0000_005C || v !== m_rd) begin failures++; $display("FAIL midreset_cap got=%h exp=%h", v, 32'h5C); end
        rd(2'd2, v);
        checks++; if (v !== 32'd0 || irq !== 1'b0) begin failures++; $display("FAIL midreset_mask got=%h irq=%b exp=0", v, irq); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++; if (readdata !== m_rd) begin failures++; $display("FAIL rand_readdata cyc=%0d got=%h exp=%h", i, readdata, m_rd); end
            checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); end
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_data_read();
        test_irq();
        test_clear();
        test_set_beats_clear();
        test_ignored_writes();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
